lru_alloc_ctrl: RTL and testbench
=================================

Name: lru_alloc_ctrl

Overview:
Replacement-side client of the tree_plru module: issues victim queries and MRU updates on behalf of a cache controller.
Accepts allocation requests on a miss and obtains the victim way. Sequences a write-back handshake when the victim is dirty, then marks the victim MRU and returns it.
Also forwards lookup hits as MRU updates, so tree_plru sees exactly one updater.

Parameters:
NUM_SETS, 32, number of cache sets
NUM_WAYS, 4, ways per set (1, 2, 4 or 8)
SET_INDEX_WIDTH, $clog2(NUM_SETS), set index width
WAY_INDEX_WIDTH, $clog2(NUM_WAYS), way index width

Ports:
Clock and reset: one clock; reset is synchronous and active-high.
clk  in  1  clock
reset  in  1  synchronous active-high reset
hit_valid  in  1  lookup hit; promote way to MRU
hit_set  in  SET_INDEX_WIDTH  hit set
hit_way  in  WAY_INDEX_WIDTH  hit way
alloc_req_valid  in  1  allocation request
alloc_req_ready  out  1  request accepted when valid&ready
alloc_set  in  SET_INDEX_WIDTH  set to allocate in
alloc_valids  in  NUM_WAYS  valid bits of the set's ways
alloc_dirty  in  NUM_WAYS  dirty bits of the set's ways
alloc_resp_valid  out  1  one-cycle pulse: allocation complete
alloc_resp_way  out  WAY_INDEX_WIDTH  allocated way
alloc_resp_replaced  out  1  victim was valid
alloc_resp_written_back  out  1  victim was written back
evict_valid  out  1  write-back request
evict_ready  in  1  write-back accepted
evict_set  out  SET_INDEX_WIDTH  write-back set
evict_way  out  WAY_INDEX_WIDTH  write-back way
lru_read_en  out  1  to tree_plru read_en
lru_read_set  out  SET_INDEX_WIDTH  to tree_plru read_set
lru_read_valids  out  NUM_WAYS  to tree_plru read_valids
lru_read_way  in  WAY_INDEX_WIDTH  from tree_plru read_way (same-cycle)
lru_update_en  out  1  to tree_plru update_en
lru_update_set  out  SET_INDEX_WIDTH  to tree_plru update_set
lru_update_way  out  WAY_INDEX_WIDTH  to tree_plru update_way

Behaviour:
- FSM states: IDLE, LOOKUP, EVICT, DONE.
- Reset: state=IDLE. All outputs 0 except alloc_req_ready=1. Captured set/valids/dirty/victim registers cleared. Applies mid-operation: a pending evict_valid drops the next cycle and no response is issued.
- IDLE: alloc_req_ready=1. On alloc_req_valid, capture alloc_set/valids/dirty, go to LOOKUP.
- LOOKUP: lru_read_en=1, lru_read_set and lru_read_valids come from the captured registers; lru_read_way is sampled into the victim register.
  - If hit_valid && hit_set==captured set in the same cycle, discard the sample and stay in LOOKUP one more cycle. This avoids stale flags, because tree_plru writes on the edge.
  - Otherwise, with replaced = valids[victim]: if replaced && dirty[victim] go to EVICT, else go to DONE.
- EVICT: evict_valid=1 with evict_set/evict_way held stable until evict_ready. Go to DONE on the cycle after evict_valid&&evict_ready. evict_ready while not in EVICT is ignored.
- DONE: the update port is shared, and hits have absolute priority.
  - If hit_valid, forward the hit and stay in DONE.
  - Else drive lru_update_en=1 with captured set and victim, pulse alloc_resp_valid with way, replaced, and written_back (=EVICT visited). Then go to IDLE; the next request can be accepted 1 cycle later.
- Hit path: in every state, hit_valid produces lru_update_en=1, lru_update_set=hit_set, lru_update_way=hit_way in the same cycle (combinational). hit_valid stalls DONE only.
  - Upstream guarantees hit_valid is not asserted continuously; there is no starvation guard.
- Empty ways: if any alloc_valids bit is 0, tree_plru returns the lowest invalid way. The response then has replaced=0 and written_back=0.
- NUM_WAYS=1: victim is always 0.
- Minimum latency, request accepted to response: 2 cycles (LOOKUP, DONE) clean; 3 + evict_ready wait when dirty.
- Outputs are registered from FSM state, except the hit-forwarding update mux and lru_read_* (direct from captured registers, gated by state).

Decomposition:
- Shared package: lru_alloc_state_t enum (IDLE, LOOKUP, EVICT, DONE).
- Allocation response struct: way, replaced, written_back.
- No sub-module. The bench instantiates tree_plru as the real partner.

Test Plan:
- Clean miss: 4 ways, set 5, valids=4'b1111, dirty=0, fresh reset → resp 2 cycles after accept with way=0, replaced=1, written_back=0; lru_update_en set=5 way=0 in the resp cycle.
- Empty way: valids=4'b1011 → resp way=2, replaced=0, evict_valid never asserted.
- Dirty victim: valids=4'b1111, dirty=4'b0001, evict_ready held low 4 cycles → evict_valid set/way stable for 5 cycles. Resp 1 cycle after handshake with written_back=1.
- Hit contention: assert hit_valid (set 3, way 1) during DONE for 2 cycles → hit updates issued those cycles, resp delayed 2 cycles. Hit to the same set during LOOKUP → extra LOOKUP cycle, victim differs from the hit way.
- Sequence: repeated allocs to set 7 with all ways valid → victims 0, 2, 1, 3 per tree order. Reset asserted during EVICT → evict_valid low the next cycle, no resp, ready=1.

Source files
------------

// File: rtl/lru_alloc_ctrl_pkg.sv
// Shared types for the LRU allocation controller: FSM state encoding and the
// allocation response record.
package lru_alloc_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    EVICT,
    DONE
  } lru_alloc_state_t;

  // Wide enough for the largest supported associativity (8 ways).
  localparam int MAX_WAY_W = 3;

  typedef struct packed {
    logic [MAX_WAY_W-1:0] way;
    logic                 replaced;
    logic                 written_back;
  } alloc_resp_t;

endpackage

// File: rtl/tree_plru.sv
// Per-set tree pseudo-LRU store: combinational victim read (lowest invalid way
// first, otherwise tree walk) and registered MRU update.
module tree_plru #(
  parameter int NUM_SETS        = 32,
  parameter int NUM_WAYS        = 4,
  parameter int SET_INDEX_WIDTH = $clog2(NUM_SETS),
  parameter int WAY_INDEX_WIDTH = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       read_en,
  input  logic [SET_INDEX_WIDTH-1:0] read_set,
  input  logic [NUM_WAYS-1:0]        read_valids,
  output logic [WAY_INDEX_WIDTH-1:0] read_way,
  input  logic                       update_en,
  input  logic [SET_INDEX_WIDTH-1:0] update_set,
  input  logic [WAY_INDEX_WIDTH-1:0] update_way
);

  localparam int LEVELS = $clog2(NUM_WAYS);
  localparam int TREE_W = (NUM_WAYS > 1) ? NUM_WAYS - 1 : 1;

  // Heap-ordered node bits: node n lives at bit n-1; 0 points left (toward LRU).
  logic [TREE_W-1:0] tree_q [NUM_SETS];
  logic [TREE_W-1:0] upd_bits;

  always_comb begin
    int                node;
    logic              found;
    logic [TREE_W-1:0] sh;
    read_way = '0;
    found    = 1'b0;
    node     = 1;
    sh       = '0;
    for (int i = 0; i < NUM_WAYS; i++) begin
      if (!found && !read_valids[i]) begin
        read_way = WAY_INDEX_WIDTH'(i);
        found    = 1'b1;
      end
    end
    if (!found) begin
      for (int l = 0; l < LEVELS; l++) begin
        sh   = tree_q[read_set] >> (node - 1);
        node = 2 * node + int'(sh[0]);
      end
      read_way = WAY_INDEX_WIDTH'(node - NUM_WAYS);
    end
    if (!read_en) read_way = '0;
  end

  always_comb begin
    int                         node;
    logic [WAY_INDEX_WIDTH-1:0] wsh;
    logic [TREE_W-1:0]          mask;
    upd_bits = tree_q[update_set];
    node     = 1;
    wsh      = '0;
    mask     = '0;
    for (int l = 0; l < LEVELS; l++) begin
      wsh      = update_way >> (LEVELS - 1 - l);
      mask     = TREE_W'(1) << (node - 1);
      upd_bits = wsh[0] ? (upd_bits & ~mask) : (upd_bits | mask);
      node     = 2 * node + int'(wsh[0]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < NUM_SETS; s++) tree_q[s] <= '0;
    end else if (update_en) begin
      tree_q[update_set] <= upd_bits;
    end
  end

endmodule

// File: rtl/lru_alloc_ctrl.sv
// Replacement-side client of tree_plru: picks a victim on allocation, runs the
// write-back handshake for dirty victims, marks the victim MRU and forwards hits.
module lru_alloc_ctrl
  import lru_alloc_ctrl_pkg::*;
#(
  parameter int NUM_SETS        = 32,
  parameter int NUM_WAYS        = 4,
  parameter int SET_INDEX_WIDTH = $clog2(NUM_SETS),
  parameter int WAY_INDEX_WIDTH = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       hit_valid,
  input  logic [SET_INDEX_WIDTH-1:0] hit_set,
  input  logic [WAY_INDEX_WIDTH-1:0] hit_way,
  input  logic                       alloc_req_valid,
  output logic                       alloc_req_ready,
  input  logic [SET_INDEX_WIDTH-1:0] alloc_set,
  input  logic [NUM_WAYS-1:0]        alloc_valids,
  input  logic [NUM_WAYS-1:0]        alloc_dirty,
  output logic                       alloc_resp_valid,
  output logic [WAY_INDEX_WIDTH-1:0] alloc_resp_way,
  output logic                       alloc_resp_replaced,
  output logic                       alloc_resp_written_back,
  output logic                       evict_valid,
  input  logic                       evict_ready,
  output logic [SET_INDEX_WIDTH-1:0] evict_set,
  output logic [WAY_INDEX_WIDTH-1:0] evict_way,
  output logic                       lru_read_en,
  output logic [SET_INDEX_WIDTH-1:0] lru_read_set,
  output logic [NUM_WAYS-1:0]        lru_read_valids,
  input  logic [WAY_INDEX_WIDTH-1:0] lru_read_way,
  output logic                       lru_update_en,
  output logic [SET_INDEX_WIDTH-1:0] lru_update_set,
  output logic [WAY_INDEX_WIDTH-1:0] lru_update_way
);

  lru_alloc_state_t           state_q;
  logic [SET_INDEX_WIDTH-1:0] set_q;
  logic [NUM_WAYS-1:0]        valids_q;
  logic [NUM_WAYS-1:0]        dirty_q;
  alloc_resp_t                resp_q;
  logic                       ready_q;
  logic                       evict_q;

  logic [WAY_INDEX_WIDTH-1:0] victim;
  logic                       lookup_stall;
  logic                       read_replaced;
  logic                       read_dirty;

  assign victim        = resp_q.way[WAY_INDEX_WIDTH-1:0];
  // A same-set hit rewrites the tree on this edge, so this cycle's read is stale.
  assign lookup_stall  = hit_valid && (hit_set == set_q);
  assign read_replaced = valids_q[lru_read_way];
  assign read_dirty    = dirty_q[lru_read_way];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      set_q    <= '0;
      valids_q <= '0;
      dirty_q  <= '0;
      resp_q   <= '0;
      ready_q  <= 1'b1;
      evict_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (alloc_req_valid) begin
            set_q    <= alloc_set;
            valids_q <= alloc_valids;
            dirty_q  <= alloc_dirty;
            resp_q   <= '0;
            ready_q  <= 1'b0;
            state_q  <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (!lookup_stall) begin
            resp_q.way      <= MAX_WAY_W'(lru_read_way);
            resp_q.replaced <= read_replaced;
            if (read_replaced && read_dirty) begin
              evict_q <= 1'b1;
              state_q <= EVICT;
            end else begin
              state_q <= DONE;
            end
          end
        end
        EVICT: begin
          if (evict_ready) begin
            evict_q             <= 1'b0;
            resp_q.written_back <= 1'b1;
            state_q             <= DONE;
          end
        end
        DONE: begin
          if (!hit_valid) begin
            ready_q <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign alloc_req_ready         = ready_q;
  assign alloc_resp_valid        = (state_q == DONE) && !hit_valid;
  assign alloc_resp_way          = victim;
  assign alloc_resp_replaced     = resp_q.replaced;
  assign alloc_resp_written_back = resp_q.written_back;

  assign evict_valid = evict_q;
  assign evict_set   = evict_q ? set_q : '0;
  assign evict_way   = evict_q ? victim : '0;

  assign lru_read_en     = (state_q == LOOKUP);
  assign lru_read_set    = lru_read_en ? set_q : '0;
  assign lru_read_valids = lru_read_en ? valids_q : '0;

  // Hits own the update port; the allocation's MRU write waits behind them.
  always_comb begin
    lru_update_en  = 1'b0;
    lru_update_set = '0;
    lru_update_way = '0;
    if (hit_valid) begin
      lru_update_en  = 1'b1;
      lru_update_set = hit_set;
      lru_update_way = hit_way;
    end else if (state_q == DONE) begin
      lru_update_en  = 1'b1;
      lru_update_set = set_q;
      lru_update_way = victim;
    end
  end

endmodule

// File: tb/tb_lru_alloc_ctrl.sv
// Directed bench for lru_alloc_ctrl paired with tree_plru.
module tb_lru_alloc_ctrl;

  localparam int NUM_SETS = 32;
  localparam int NUM_WAYS = 4;
  localparam int SW = $clog2(NUM_SETS);
  localparam int WW = $clog2(NUM_WAYS);

  logic          clk = 1'b0;
  logic          reset;
  logic          hit_valid;
  logic [SW-1:0] hit_set;
  logic [WW-1:0] hit_way;
  logic          alloc_req_valid;
  logic          alloc_req_ready;
  logic [SW-1:0] alloc_set;
  logic [3:0]    alloc_valids;
  logic [3:0]    alloc_dirty;
  logic          alloc_resp_valid;
  logic [WW-1:0] alloc_resp_way;
  logic          alloc_resp_replaced;
  logic          alloc_resp_written_back;
  logic          evict_valid;
  logic          evict_ready;
  logic [SW-1:0] evict_set;
  logic [WW-1:0] evict_way;
  logic          lru_read_en;
  logic [SW-1:0] lru_read_set;
  logic [3:0]    lru_read_valids;
  logic [WW-1:0] lru_read_way;
  logic          lru_update_en;
  logic [SW-1:0] lru_update_set;
  logic [WW-1:0] lru_update_way;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  lru_alloc_ctrl #(.NUM_SETS(NUM_SETS), .NUM_WAYS(NUM_WAYS)) dut (
    .clk(clk), .reset(reset),
    .hit_valid(hit_valid), .hit_set(hit_set), .hit_way(hit_way),
    .alloc_req_valid(alloc_req_valid), .alloc_req_ready(alloc_req_ready),
    .alloc_set(alloc_set), .alloc_valids(alloc_valids), .alloc_dirty(alloc_dirty),
    .alloc_resp_valid(alloc_resp_valid), .alloc_resp_way(alloc_resp_way),
    .alloc_resp_replaced(alloc_resp_replaced),
    .alloc_resp_written_back(alloc_resp_written_back),
    .evict_valid(evict_valid), .evict_ready(evict_ready),
    .evict_set(evict_set), .evict_way(evict_way),
    .lru_read_en(lru_read_en), .lru_read_set(lru_read_set),
    .lru_read_valids(lru_read_valids), .lru_read_way(lru_read_way),
    .lru_update_en(lru_update_en), .lru_update_set(lru_update_set),
    .lru_update_way(lru_update_way)
  );

  tree_plru #(.NUM_SETS(NUM_SETS), .NUM_WAYS(NUM_WAYS)) plru (
    .clk(clk), .reset(reset),
    .read_en(lru_read_en), .read_set(lru_read_set),
    .read_valids(lru_read_valids), .read_way(lru_read_way),
    .update_en(lru_update_en), .update_set(lru_update_set),
    .update_way(lru_update_way)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts in an IDLE cycle and returns at the start of the following IDLE cycle.
  task automatic run_alloc(input string tag, input logic [SW-1:0] s, input logic [3:0] v,
                           input logic [3:0] d, input int lk_hit, input logic [WW-1:0] lk_hw,
                           input int n_hits, input int ev_wait, input logic [WW-1:0] exp_way,
                           input logic exp_rep, input logic exp_wb);
    alloc_req_valid = 1'b1;
    alloc_set       = s;
    alloc_valids    = v;
    alloc_dirty     = d;
    #1;
    check_val({tag, "_ready"}, 32'(alloc_req_ready), 32'(1));
    step();
    alloc_req_valid = 1'b0;
    if (lk_hit != 0) begin
      hit_valid = 1'b1;
      hit_set   = s;
      hit_way   = lk_hw;
      #1;
      check_val({tag, "_lkhit_upd_en"}, 32'(lru_update_en), 32'(1));
      check_val({tag, "_lkhit_upd_way"}, 32'(lru_update_way), 32'(lk_hw));
      check_val({tag, "_lkhit_resp"}, 32'(alloc_resp_valid), 32'(0));
      step();
      hit_valid = 1'b0;
    end
    #1;
    check_val({tag, "_read_en"}, 32'(lru_read_en), 32'(1));
    check_val({tag, "_read_set"}, 32'(lru_read_set), 32'(s));
    check_val({tag, "_read_valids"}, 32'(lru_read_valids), 32'(v));
    check_val({tag, "_lk_evict"}, 32'(evict_valid), 32'(0));
    step();
    if (ev_wait >= 0) begin
      for (int i = 0; i <= ev_wait; i++) begin
        evict_ready = (i == ev_wait);
        #1;
        check_val({tag, "_ev_valid"}, 32'(evict_valid), 32'(1));
        check_val({tag, "_ev_set"}, 32'(evict_set), 32'(s));
        check_val({tag, "_ev_way"}, 32'(evict_way), 32'(exp_way));
        check_val({tag, "_ev_resp"}, 32'(alloc_resp_valid), 32'(0));
        step();
      end
      evict_ready = 1'b0;
    end
    for (int h = 0; h < n_hits; h++) begin
      hit_valid = 1'b1;
      hit_set   = 5'd3;
      hit_way   = 2'd1;
      #1;
      check_val({tag, "_dhit_resp"}, 32'(alloc_resp_valid), 32'(0));
      check_val({tag, "_dhit_upd_en"}, 32'(lru_update_en), 32'(1));
      check_val({tag, "_dhit_upd_set"}, 32'(lru_update_set), 32'(3));
      check_val({tag, "_dhit_upd_way"}, 32'(lru_update_way), 32'(1));
      step();
    end
    hit_valid = 1'b0;
    #1;
    check_val({tag, "_resp_valid"}, 32'(alloc_resp_valid), 32'(1));
    check_val({tag, "_resp_way"}, 32'(alloc_resp_way), 32'(exp_way));
    check_val({tag, "_resp_repl"}, 32'(alloc_resp_replaced), 32'(exp_rep));
    check_val({tag, "_resp_wb"}, 32'(alloc_resp_written_back), 32'(exp_wb));
    check_val({tag, "_upd_en"}, 32'(lru_update_en), 32'(1));
    check_val({tag, "_upd_set"}, 32'(lru_update_set), 32'(s));
    check_val({tag, "_upd_way"}, 32'(lru_update_way), 32'(exp_way));
    check_val({tag, "_done_evict"}, 32'(evict_valid), 32'(0));
    check_val({tag, "_done_ready"}, 32'(alloc_req_ready), 32'(0));
    step();
    #1;
    check_val({tag, "_idle_ready"}, 32'(alloc_req_ready), 32'(1));
    check_val({tag, "_idle_resp"}, 32'(alloc_resp_valid), 32'(0));
  endtask

  initial begin
    reset           = 1'b1;
    hit_valid       = 1'b0;
    hit_set         = '0;
    hit_way         = '0;
    alloc_req_valid = 1'b0;
    alloc_set       = '0;
    alloc_valids    = '0;
    alloc_dirty     = '0;
    evict_ready     = 1'b0;
    repeat (2) step();
    #1;
    check_val("rst_ready", 32'(alloc_req_ready), 32'(1));
    check_val("rst_resp", 32'(alloc_resp_valid), 32'(0));
    check_val("rst_evict", 32'(evict_valid), 32'(0));
    check_val("rst_read_en", 32'(lru_read_en), 32'(0));
    check_val("rst_upd_en", 32'(lru_update_en), 32'(0));
    check_val("rst_resp_way", 32'(alloc_resp_way), 32'(0));
    reset = 1'b0;
    step();

    run_alloc("clean", 5'd5, 4'b1111, 4'b0000, 0, 2'd0, 0, -1, 2'd0, 1'b1, 1'b0);
    run_alloc("empty", 5'd6, 4'b1011, 4'b0000, 0, 2'd0, 0, -1, 2'd2, 1'b0, 1'b0);
    run_alloc("dirty", 5'd4, 4'b1111, 4'b0001, 0, 2'd0, 0, 4, 2'd0, 1'b1, 1'b1);
    run_alloc("empty_dirty", 5'd11, 4'b1101, 4'b1111, 0, 2'd0, 0, -1, 2'd1, 1'b0, 1'b0);
    run_alloc("done_hit", 5'd10, 4'b1111, 4'b0000, 0, 2'd0, 2, -1, 2'd0, 1'b1, 1'b0);
    run_alloc("lk_hit", 5'd12, 4'b1111, 4'b0000, 1, 2'd0, 0, -1, 2'd2, 1'b1, 1'b0);

    run_alloc("seq0", 5'd7, 4'b1111, 4'b0000, 0, 2'd0, 0, -1, 2'd0, 1'b1, 1'b0);
    run_alloc("seq1", 5'd7, 4'b1111, 4'b0000, 0, 2'd0, 0, -1, 2'd2, 1'b1, 1'b0);
    run_alloc("seq2", 5'd7, 4'b1111, 4'b0000, 0, 2'd0, 0, -1, 2'd1, 1'b1, 1'b0);
    run_alloc("seq3", 5'd7, 4'b1111, 4'b0000, 0, 2'd0, 0, -1, 2'd3, 1'b1, 1'b0);

    // Reset landing in the middle of a write-back.
    alloc_req_valid = 1'b1;
    alloc_set       = 5'd8;
    alloc_valids    = 4'b1111;
    alloc_dirty     = 4'b0001;
    step();
    alloc_req_valid = 1'b0;
    step();
    #1;
    check_val("rstev_evict_before", 32'(evict_valid), 32'(1));
    reset = 1'b1;
    step();
    #1;
    check_val("rstev_evict_after", 32'(evict_valid), 32'(0));
    check_val("rstev_ready", 32'(alloc_req_ready), 32'(1));
    check_val("rstev_resp", 32'(alloc_resp_valid), 32'(0));
    check_val("rstev_read_en", 32'(lru_read_en), 32'(0));
    reset = 1'b0;
    step();
    #1;
    check_val("rstev_resp2", 32'(alloc_resp_valid), 32'(0));
    check_val("rstev_evict2", 32'(evict_valid), 32'(0));
    check_val("rstev_ready2", 32'(alloc_req_ready), 32'(1));
    step();
    run_alloc("post_rst", 5'd8, 4'b1111, 4'b0000, 0, 2'd0, 0, -1, 2'd0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
